// File: rtl/div8_seq_if.sv
// Handshake and operand/result bundle for the div8_seq sequential divider.
interface div8_seq_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dz
    );
endinterface

// File: rtl/div8_seq.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, MSB first,
// with a divide-by-zero shortcut straight from IDLE to DONE.
module div8_seq (
    input  logic       clk,
    input  logic       rst,
    div8_seq_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;      // dividend bits shift out, quotient bits shift in
    logic [7:0] b_q, b_d;
    logic [8:0] p_q, p_d;      // partial remainder
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dz_q, dz_d;

    logic [8:0] shifted;
    logic [9:0] sub;
    logic       borrow_in;
    logic       borrow;
    logic       q_bit;
    logic [8:0] p_next;

    assign borrow_in = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            p_q     <= 9'd0;
            cnt_q   <= 4'd0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Trial subtract; bit 9 of the 10-bit result is the borrow-out.
    always_comb begin
        shifted = {p_q[7:0], a_q[7]};
        sub     = {1'b0, shifted} - {2'b00, b_q} - {9'd0, borrow_in};
        borrow  = sub[9];
        q_bit   = ~borrow;
        p_next  = borrow ? shifted : sub[8:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.divisor != 8'd0) begin
                        a_d     = bus.dividend;
                        b_d     = bus.divisor;
                        p_d     = 9'd0;
                        cnt_d   = 4'd0;
                        state_d = StRun;
                    end else begin
                        quo_d   = 8'hFF;
                        rem_d   = bus.dividend;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                p_d   = p_next;
                a_d   = {a_q[6:0], q_bit};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    quo_d   = {a_q[6:0], q_bit};
                    rem_d   = p_next[7:0];
                    dz_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.dz        = dz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Directed and randomized checks of div8_seq against hand-computed results
// and a behavioural divide model.
module tb_div8_seq;

    logic clk = 1'b0;
    logic rst;

    div8_seq_if bus ();

    div8_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then wait for done; lat counts edges after the accepting edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic busy_ok);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 8'h00;
        lat     = 0;
        busy_ok = bus.busy;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
            if (!bus.busy) busy_ok = 1'b0;
        end
        if (!bus.done) check("timeout", 32'(lat), 32'd8);
    endtask

    int         lat;
    logic       bok;
    logic [7:0] ea, eb, eq, er;
    logic       edz;

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_quo", 32'(bus.quotient), 32'd0);
        check("rst_rem", 32'(bus.remainder), 32'd0);
        check("rst_dz", 32'(bus.dz), 32'd0);

        // 100/7
        run_op(8'd100, 8'd7, lat, bok);
        check("basic_lat", 32'(lat), 32'd8);
        check("basic_busy", 32'(bok), 32'd1);
        check("basic_quo", 32'(bus.quotient), 32'd14);
        check("basic_rem", 32'(bus.remainder), 32'd2);
        check("basic_dz", 32'(bus.dz), 32'd0);
        tick();
        check("basic_done_pulse", 32'(bus.done), 32'd0);
        check("basic_idle_busy", 32'(bus.busy), 32'd0);
        check("basic_hold_quo", 32'(bus.quotient), 32'd14);

        // Extremes
        run_op(8'd255, 8'd1, lat, bok);
        check("255_1_quo", 32'(bus.quotient), 32'd255);
        check("255_1_rem", 32'(bus.remainder), 32'd0);
        tick();
        run_op(8'd5, 8'd10, lat, bok);
        check("5_10_quo", 32'(bus.quotient), 32'd0);
        check("5_10_rem", 32'(bus.remainder), 32'd5);
        tick();
        run_op(8'd255, 8'd255, lat, bok);
        check("255_255_quo", 32'(bus.quotient), 32'd1);
        check("255_255_rem", 32'(bus.remainder), 32'd0);
        tick();

        // Divide by zero, then a normal op clears dz
        run_op(8'd200, 8'd0, lat, bok);
        check("dz_lat", 32'(lat), 32'd0);
        check("dz_busy", 32'(bus.busy), 32'd1);
        check("dz_quo", 32'(bus.quotient), 32'hFF);
        check("dz_rem", 32'(bus.remainder), 32'hC8);
        check("dz_flag", 32'(bus.dz), 32'd1);
        tick();
        check("dz_done_pulse", 32'(bus.done), 32'd0);
        run_op(8'd9, 8'd3, lat, bok);
        check("after_dz_quo", 32'(bus.quotient), 32'd3);
        check("after_dz_flag", 32'(bus.dz), 32'd0);
        tick();

        // Start with new operands at RUN edge N+3 must be ignored
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 8'd77;
        bus.divisor  = 8'd2;
        tick();
        tick();
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        tick();
        bus.start = 1'b0;
        lat = 3;
        tick();
        lat++;
        check("run_hold_quo", 32'(bus.quotient), 32'd3);
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check("reject_lat", 32'(lat), 32'd8);
        check("reject_quo", 32'(bus.quotient), 32'd14);
        check("reject_rem", 32'(bus.remainder), 32'd2);
        tick();
        tick();
        check("reject_no_restart", 32'(bus.busy), 32'd0);

        // Reset asserted at RUN edge N+4
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd9;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_quo", 32'(bus.quotient), 32'd0);
        check("midrst_rem", 32'(bus.remainder), 32'd0);
        check("midrst_dz", 32'(bus.dz), 32'd0);
        bok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) bok = 1'b1;
        end
        check("midrst_quiet", 32'(bok), 32'd0);
        run_op(8'd9, 8'd3, lat, bok);
        check("midrst_new_quo", 32'(bus.quotient), 32'd3);
        check("midrst_new_rem", 32'(bus.remainder), 32'd0);
        tick();

        // start held high: back-to-back operations
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        tick();
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_lat1", 32'(lat), 32'd8);
        tick();
        check("b2b_idle", 32'(bus.busy), 32'd0);
        tick();
        check("b2b_accept", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_lat2", 32'(lat), 32'd8);
        check("b2b_quo", 32'(bus.quotient), 32'd14);
        bus.start = 1'b0;
        tick();

        // Random operand pairs, every 16th with a zero divisor
        for (int i = 0; i < 1000; i++) begin
            ea = 8'($urandom_range(0, 255));
            eb = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (eb == 8'd0) begin
                eq  = 8'hFF;
                er  = ea;
                edz = 1'b1;
            end else begin
                eq  = ea / eb;
                er  = ea % eb;
                edz = 1'b0;
            end
            run_op(ea, eb, lat, bok);
            check("rnd_quo", 32'(bus.quotient), 32'(eq));
            check("rnd_rem", 32'(bus.remainder), 32'(er));
            check("rnd_dz", 32'(bus.dz), 32'(edz));
            check("rnd_lat", 32'(lat), edz ? 32'd0 : 32'd8);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div8_seq.md
DIV8_SEQ -- requirements
Module: div8_seq

Interface
REQ-001 Parameters: none; all datapath widths are fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned dividend; captured on the accepting edge.
REQ-006 divisor  input  8  unsigned divisor; captured on the accepting edge.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  single-cycle pulse; results are valid in that cycle.
REQ-009 quotient  output  8  registered unsigned quotient.
REQ-010 remainder  output  8  registered unsigned remainder.
REQ-011 dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 and divisor!=0 on edge N SHALL:
  - capture the operands;
  - clear the partial remainder;
  - clear the 4-bit iteration counter;
  - enter RUN.
REQ-014 IDLE with start=1 and divisor==0 on edge N SHALL:
  - load quotient=8'hFF, remainder=dividend and dz=1;
  - enter DONE, so done is high from edge N to N+1.
REQ-015 On each RUN edge, the block SHALL perform one restoring step, MSB first:
  - shift the 9-bit partial remainder left, with the next dividend bit entering bit 0;
  - compute a 9-bit trial subtract of the divisor with borrow-out;
  - if borrow=0, keep the difference and set quotient bit=1;
  - if borrow=1, keep the shifted value and set quotient bit=0.
REQ-016 The subtraction SHALL be a subtract-with-borrow: difference = a - b - borrow_in, with borrow_in tied 0; the borrow-out alone decides restore.
REQ-017 RUN SHALL last exactly 8 edges (N+1..N+8).
REQ-018 On edge N+8, the block SHALL register quotient, remainder (low 8 bits of the partial remainder) and dz=0, and enter DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing and no restart.
REQ-021 Operand inputs SHALL be don't-care outside the accepting edge; changes during RUN SHALL not affect the result.
REQ-022 quotient, remainder and dz SHALL hold their values from DONE until the next DONE; they SHALL not change during RUN.
REQ-023 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-024 Results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for every divisor != 0.
REQ-025 start held high continuously SHALL yield back-to-back operations, each accepted in the IDLE cycle after DONE.

Reset
REQ-026 rst=1 SHALL take priority over all other inputs on any edge, including mid-RUN and in DONE.
REQ-027 After reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, dz=0, counter=0, partial remainder=0.
REQ-028 An operation interrupted by reset SHALL be discarded; no done pulse SHALL be produced for it.

Verification
REQ-029 Basic division: start with 100/7 on edge N -> done high N+8..N+9, quotient=14, remainder=2, dz=0; busy high N..N+9.
REQ-030 Extremes:
  - 255/1 -> quotient=255, remainder=0;
  - 5/10 -> quotient=0, remainder=5;
  - 255/255 -> quotient=1, remainder=0.
REQ-031 Divide-by-zero: 200/0 on edge N -> done high N..N+1, quotient=8'hFF, remainder=8'hC8, dz=1; a following 9/3 clears dz and gives quotient=3.
REQ-032 Busy rejection: start=1 with new operands at RUN edge N+3 -> ignored; the original result is delivered unchanged at N+8.
REQ-033 Reset mid-operation: rst=1 at edge N+4 -> all outputs reset and no done pulse; a new start after rst deasserts completes correctly.
REQ-034 Random check: at least 1000 random operand pairs, including divisor 0, checked against REQ-024 and the REQ-014 result values.
